// File: rtl/systolic_pkg.sv
// Shared helpers for the systolic PE: saturation limits, overflow detection and mode constants.
// Functions work on a MAX_ACC_W-wide container; callers size-cast down to their ACC_W.
package systolic_pkg;

  localparam int MAX_ACC_W     = 128;
  localparam int MODE_UNSIGNED = 0;
  localparam int MODE_SIGNED   = 1;
  localparam int MODE_WRAP     = 0;
  localparam int MODE_SAT      = 1;
  localparam int MUL_COMB      = 0;
  localparam int MUL_PIPE      = 1;

  typedef enum logic [1:0] {
    ACC_HOLD,
    ACC_LOAD,
    ACC_ADD,
    ACC_FLUSH
  } acc_op_e;

  function automatic logic [MAX_ACC_W-1:0] acc_sat_max(input int acc_w, input logic is_signed);
    logic [MAX_ACC_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_ACC_W; i++) begin
      v[i] = (i < acc_w - (is_signed ? 1 : 0));
    end
    return v;
  endfunction

  function automatic logic [MAX_ACC_W-1:0] acc_sat_min(input int acc_w, input logic is_signed);
    logic [MAX_ACC_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_ACC_W; i++) begin
      v[i] = is_signed && (i == acc_w - 1);
    end
    return v;
  endfunction

  // Signed overflow: result sign disagrees with both addend signs; unsigned: carry out.
  function automatic logic acc_ovf_detect(input logic is_signed, input logic a_msb,
                                          input logic b_msb, input logic s_msb,
                                          input logic carry);
    return is_signed ? ((s_msb ^ a_msb) & (s_msb ^ b_msb)) : carry;
  endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Multiply, optional product register, accumulator with saturate/wrap and sticky overflow.
// Accumulate commits 0 or 1 cycle after the operands (PIPE_MUL); no backpressure, fire is a pulse.
module pe_mac_unit
  import systolic_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 64,
  parameter int SIGNED   = MODE_UNSIGNED,
  parameter int SAT      = MODE_WRAP,
  parameter int PIPE_MUL = MUL_COMB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_fire,
  input  logic              i_clr,
  input  logic              i_last,
  output logic              o_close,
  output logic [ACC_W-1:0]  o_acc_nxt,
  output logic              o_ovf_nxt
);

  if (ACC_W < 2 * DATA_W || ACC_W > MAX_ACC_W) begin : g_bad_width
    $error("pe_mac_unit: ACC_W must be >= 2*DATA_W and <= MAX_ACC_W");
  end

  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_prod_ext;

  if (SIGNED != MODE_UNSIGNED) begin : g_mul_signed
    logic signed [2*DATA_W-1:0] w_a_x;
    logic signed [2*DATA_W-1:0] w_b_x;
    assign w_a_x      = (2*DATA_W)'($signed(i_a));
    assign w_b_x      = (2*DATA_W)'($signed(i_b));
    assign w_prod     = w_a_x * w_b_x;
    assign w_prod_ext = ACC_W'($signed(w_prod));
  end else begin : g_mul_unsigned
    logic [2*DATA_W-1:0] w_a_x;
    logic [2*DATA_W-1:0] w_b_x;
    assign w_a_x      = (2*DATA_W)'(i_a);
    assign w_b_x      = (2*DATA_W)'(i_b);
    assign w_prod     = w_a_x * w_b_x;
    assign w_prod_ext = ACC_W'(w_prod);
  end

  logic [ACC_W-1:0] w_p;
  logic             w_f;
  logic             w_c;
  logic             w_l;

  if (PIPE_MUL != MUL_COMB) begin : g_pipe
    logic [ACC_W-1:0] r_prod;
    logic             r_fire;
    logic             r_clr;
    logic             r_last;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_prod <= '0;
        r_fire <= 1'b0;
        r_clr  <= 1'b0;
        r_last <= 1'b0;
      end else begin
        r_prod <= w_prod_ext;
        r_fire <= i_fire;
        r_clr  <= i_clr;
        r_last <= i_last;
      end
    end
    assign w_p = r_prod;
    assign w_f = r_fire;
    assign w_c = r_clr;
    assign w_l = r_last;
  end else begin : g_comb
    assign w_p = w_prod_ext;
    assign w_f = i_fire;
    assign w_c = i_clr;
    assign w_l = i_last;
  end

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W:0]   w_sum;
  logic             w_hit;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_ovf_nxt;
  acc_op_e          w_op;

  always_comb begin
    w_base    = w_c ? '0 : r_acc;
    w_sum     = {1'b0, w_base} + {1'b0, w_p};
    w_hit     = acc_ovf_detect(SIGNED != MODE_UNSIGNED, w_base[ACC_W-1], w_p[ACC_W-1],
                               w_sum[ACC_W-1], w_sum[ACC_W]);
    w_acc_nxt = w_sum[ACC_W-1:0];
    // An overflow implies equal addend signs, so the base sign picks the clamp direction.
    if (SAT != MODE_WRAP && w_hit) begin
      if (SIGNED != MODE_UNSIGNED && w_base[ACC_W-1]) begin
        w_acc_nxt = ACC_W'(acc_sat_min(ACC_W, 1'b1));
      end else begin
        w_acc_nxt = ACC_W'(acc_sat_max(ACC_W, SIGNED != MODE_UNSIGNED));
      end
    end
    w_ovf_nxt = (w_c ? 1'b0 : r_ovf) | w_hit;
    if (w_f) begin
      w_op = w_c ? ACC_LOAD : ACC_ADD;
    end else if (w_c) begin
      w_op = ACC_FLUSH;
    end else begin
      w_op = ACC_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (w_op)
        ACC_LOAD, ACC_ADD: begin
          r_acc <= w_acc_nxt;
          r_ovf <= w_ovf_nxt;
        end
        ACC_FLUSH: begin
          r_acc <= '0;
          r_ovf <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_close   = w_f & w_l;
  assign o_acc_nxt = w_acc_nxt;
  assign o_ovf_nxt = w_ovf_nxt;

endmodule

// File: rtl/systolic_pe_mac.sv
// Output-stationary systolic PE: 1-cycle operand forwarding, MAC with tile framing.
// result_vld pulses 1+PIPE_MUL cycles after the last term; no backpressure (valid-only flow).
module systolic_pe_mac
  import systolic_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 64,
  parameter int SIGNED   = MODE_UNSIGNED,
  parameter int SAT      = MODE_WRAP,
  parameter int PIPE_MUL = MUL_COMB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inp_north,
  input  logic              vld_north,
  input  logic [DATA_W-1:0] inp_west,
  input  logic              vld_west,
  input  logic              acc_clr,
  input  logic              acc_last,
  output logic [DATA_W-1:0] outp_south,
  output logic              vld_south,
  output logic [DATA_W-1:0] outp_east,
  output logic              vld_east,
  output logic [ACC_W-1:0]  result,
  output logic              result_vld,
  output logic              ovf
);

  logic [DATA_W-1:0] r_outp_south;
  logic              r_vld_south;
  logic [DATA_W-1:0] r_outp_east;
  logic              r_vld_east;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outp_south <= '0;
      r_vld_south  <= 1'b0;
      r_outp_east  <= '0;
      r_vld_east   <= 1'b0;
    end else begin
      r_vld_south <= vld_north;
      r_vld_east  <= vld_west;
      if (vld_north) r_outp_south <= inp_north;
      if (vld_west)  r_outp_east  <= inp_west;
    end
  end

  logic             w_fire;
  logic             w_close;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_ovf_nxt;

  assign w_fire = vld_north & vld_west;

  pe_mac_unit #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .SIGNED  (SIGNED),
    .SAT     (SAT),
    .PIPE_MUL(PIPE_MUL)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst),
    .i_a      (inp_north),
    .i_b      (inp_west),
    .i_fire   (w_fire),
    .i_clr    (acc_clr),
    .i_last   (acc_last),
    .o_close  (w_close),
    .o_acc_nxt(w_acc_nxt),
    .o_ovf_nxt(w_ovf_nxt)
  );

  logic [ACC_W-1:0] r_result;
  logic             r_result_vld;
  logic             r_ovf;

  // ovf is snapshotted with result so both describe the same closed tile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result     <= '0;
      r_result_vld <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_result_vld <= w_close;
      if (w_close) begin
        r_result <= w_acc_nxt;
        r_ovf    <= w_ovf_nxt;
      end
    end
  end

  assign outp_south = r_outp_south;
  assign vld_south  = r_vld_south;
  assign outp_east  = r_outp_east;
  assign vld_east   = r_vld_east;
  assign result     = r_result;
  assign result_vld = r_result_vld;
  assign ovf        = r_ovf;

endmodule
